// File: rtl/timer_pkg.sv
// Shared BCD constants, count-direction encoding and digit validation helper
// for the cascaded BCD timer.
package timer_pkg;
  localparam int BCD_W = 4;

  typedef enum logic {
    MODE_UP   = 1'b0,
    MODE_DOWN = 1'b1
  } mode_e;

  localparam logic [BCD_W-1:0] UNITS_MAX = 4'd9;
  localparam logic [BCD_W-1:0] TENS_MAX  = 4'd5;

  function automatic logic bcd_valid(input logic [BCD_W-1:0] digit,
                                     input logic [BCD_W-1:0] max);
    return digit <= max;
  endfunction
endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the timer chain: up/down step with carry/borrow out, load,
// and an optional runtime maximum that replaces DIGIT_MAX.
module bcd_digit
  import timer_pkg::*;
#(
  parameter logic [BCD_W-1:0] DIGIT_MAX = UNITS_MAX
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load_i,
  input  logic [BCD_W-1:0] load_val_i,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic             max_ovr_i,
  input  logic [BCD_W-1:0] max_i,
  output logic [BCD_W-1:0] digit_o,
  output logic [BCD_W-1:0] digit_d_o,
  output logic             carry_o,
  output logic             term_o
);
  logic [BCD_W-1:0] digit_q, digit_d, max_eff;

  assign max_eff = max_ovr_i ? max_i : DIGIT_MAX;

  // Terminal means "the next step rolls over": at max going up, at zero going down.
  assign term_o  = (mode_i == MODE_UP) ? (digit_q >= max_eff) : (digit_q == '0);
  assign carry_o = en_i & term_o;

  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = load_val_i;
    end else if (en_i) begin
      if (mode_i == MODE_UP) digit_d = term_o ? '0 : digit_q + 1'b1;
      else                   digit_d = term_o ? max_eff : digit_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) digit_q <= '0;
    else     digit_q <= digit_d;
  end

  assign digit_o   = digit_q;
  assign digit_d_o = digit_d;
endmodule

// File: rtl/bcd_timer_chain.sv
// Multi-field BCD timer (SS, MM:SS, HH:MM:SS...) with limited top field,
// stop-at-zero countdown, wrap/done/load-error flags and a lap-freeze display.
module bcd_timer_chain
  import timer_pkg::*;
#(
  parameter int NUM_PAIRS    = 2,
  parameter int TOP_LIMIT    = 59,
  parameter bit STOP_AT_ZERO = 1'b1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         LOAD,
  input  logic                         COUNT,
  input  logic                         MODE,
  input  logic                         LAP,
  input  logic [BCD_W*2*NUM_PAIRS-1:0] I,
  output logic [BCD_W*2*NUM_PAIRS-1:0] CNT,
  output logic [BCD_W*2*NUM_PAIRS-1:0] Q,
  output logic                         WRAP,
  output logic                         DONE,
  output logic                         LOAD_ERR
);
  localparam int NUM_DIGITS = 2 * NUM_PAIRS;
  localparam int W          = BCD_W * NUM_DIGITS;
  localparam int TOP_T      = NUM_DIGITS - 1;
  localparam int TOP_U      = NUM_DIGITS - 2;
  localparam logic [BCD_W-1:0] TOP_TENS_MAX  = BCD_W'(TOP_LIMIT / 10);
  localparam logic [BCD_W-1:0] TOP_UNITS_MAX = BCD_W'(TOP_LIMIT % 10);

  function automatic logic [BCD_W-1:0] units_limit(input logic [BCD_W-1:0] tens);
    return (tens == TOP_TENS_MAX) ? TOP_UNITS_MAX : UNITS_MAX;
  endfunction

  logic [W-1:0]          cnt, cnt_d, ld_val;
  logic [NUM_DIGITS:0]   en_chain;
  logic [NUM_DIGITS-1:0] term, ld_err;
  logic                  stall, count_go;

  // Top-field units maximum depends on the tens digit it will sit beside
  // after the step: current tens going up, borrowed tens going down.
  logic [BCD_W-1:0] top_tens_q, top_tens_dn, top_units_max;
  assign top_tens_q    = cnt[BCD_W*TOP_T +: BCD_W];
  assign top_tens_dn   = (top_tens_q == '0) ? TOP_TENS_MAX : top_tens_q - 1'b1;
  assign top_units_max = units_limit((MODE == MODE_DOWN) ? top_tens_dn : top_tens_q);

  logic [BCD_W-1:0] ld_tt, ld_tu, top_ld_tens, top_ld_units;
  logic [6:0]       ld_top_val;
  logic             top_ld_err;

  always_comb begin
    ld_tt      = I[BCD_W*TOP_T +: BCD_W];
    ld_tu      = I[BCD_W*TOP_U +: BCD_W];
    top_ld_err = 1'b0;
    if (!bcd_valid(ld_tt, UNITS_MAX)) begin
      ld_tt      = UNITS_MAX;
      top_ld_err = 1'b1;
    end
    if (!bcd_valid(ld_tu, UNITS_MAX)) begin
      ld_tu      = UNITS_MAX;
      top_ld_err = 1'b1;
    end
    ld_top_val   = 7'(ld_tt) * 7'd10 + 7'(ld_tu);
    top_ld_tens  = ld_tt;
    top_ld_units = ld_tu;
    if (int'(ld_top_val) > TOP_LIMIT) begin
      top_ld_tens  = TOP_TENS_MAX;
      top_ld_units = TOP_UNITS_MAX;
      top_ld_err   = 1'b1;
    end
  end

  // In down mode every digit's terminal flag is "digit is zero", so the AND
  // of them is the all-zero detect used to stall the countdown.
  assign stall       = STOP_AT_ZERO && (MODE == MODE_DOWN) && (&term);
  assign count_go    = COUNT && !LOAD && !stall;
  assign en_chain[0] = count_go;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    localparam bit IS_TOP  = (gi >= NUM_DIGITS - 2);
    localparam bit IS_TENS = ((gi % 2) == 1);
    localparam logic [BCD_W-1:0] DMAX =
      !IS_TENS ? UNITS_MAX : (IS_TOP ? TOP_TENS_MAX : TENS_MAX);

    if (IS_TOP) begin : g_top
      assign ld_val[BCD_W*gi +: BCD_W] = IS_TENS ? top_ld_tens : top_ld_units;
      assign ld_err[gi]                = top_ld_err;
    end else begin : g_low
      logic [BCD_W-1:0] ld_raw;
      assign ld_raw                    = I[BCD_W*gi +: BCD_W];
      assign ld_val[BCD_W*gi +: BCD_W] = bcd_valid(ld_raw, DMAX) ? ld_raw : DMAX;
      assign ld_err[gi]                = !bcd_valid(ld_raw, DMAX);
    end

    bcd_digit #(
      .DIGIT_MAX(DMAX)
    ) u_digit (
      .CLK       (CLK),
      .RST       (RST),
      .load_i    (LOAD),
      .load_val_i(ld_val[BCD_W*gi +: BCD_W]),
      .en_i      (en_chain[gi]),
      .mode_i    (MODE),
      .max_ovr_i (IS_TOP && !IS_TENS),
      .max_i     (top_units_max),
      .digit_o   (cnt[BCD_W*gi +: BCD_W]),
      .digit_d_o (cnt_d[BCD_W*gi +: BCD_W]),
      .carry_o   (en_chain[gi+1]),
      .term_o    (term[gi])
    );
  end

  logic         wrap_q, wrap_d, done_q, done_d, load_err_q, load_err_d, lap_prev_q;
  logic [W-1:0] lap_q, lap_d;

  assign wrap_d     = en_chain[NUM_DIGITS];
  assign load_err_d = LOAD && (|ld_err);
  assign lap_d      = (LAP && !lap_prev_q) ? cnt_d : lap_q;

  always_comb begin
    done_d = done_q;
    if (!STOP_AT_ZERO)  done_d = 1'b0;
    else if (LOAD)      done_d = (MODE == MODE_DOWN) && (ld_val == '0);
    else if (COUNT)     done_d = (MODE == MODE_DOWN) && (cnt_d == '0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wrap_q     <= 1'b0;
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
      lap_prev_q <= 1'b0;
      lap_q      <= '0;
    end else begin
      wrap_q     <= wrap_d;
      done_q     <= done_d;
      load_err_q <= load_err_d;
      lap_prev_q <= LAP;
      lap_q      <= lap_d;
    end
  end

  assign CNT      = cnt;
  assign Q        = LAP ? lap_q : cnt;
  assign WRAP     = wrap_q;
  assign DONE     = done_q;
  assign LOAD_ERR = load_err_q;
endmodule
